// File: rtl/exe_mem_pipe_stage.sv
// exe_mem_pipe_stage: EX->MEM boundary register with valid/ready skid buffer, flush and bubble gating.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining PIPE_PERF_EN.
module exe_mem_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [M_W-1:0]    m_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_out,
    output logic [M_W-1:0]    m_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] rd2_out,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [DEST_W-1:0] dest_out
);
    localparam int BW = WB_W + M_W + 1 + 3 * DATA_W + DEST_W;

    logic          r_main_valid;
    logic          r_skid_valid;
    logic [BW-1:0] r_main;
    logic [BW-1:0] r_skid;
    logic [BW-1:0] w_in;
    logic          w_accept;
    logic          w_consume;
    logic [WB_W-1:0] w_wb;
    logic [M_W-1:0]  w_m;

    assign w_in      = {wb_in, m_in, zero_in, pc_in, alu_res_in, rd2_in, dest_in};
    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;
    assign {w_wb, w_m, zero_out, pc_out, alu_res_out, rd2_out, dest_out} = r_main;
    // Control fields are forced to zero on a bubble so MEM/WB never write.
    assign wb_out = r_main_valid ? w_wb : '0;
    assign m_out  = r_main_valid ? w_m : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_consume && r_skid_valid) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
        end else if (w_accept && (!r_main_valid || w_consume)) begin
            r_main       <= w_in;
            r_main_valid <= 1'b1;
        end else if (w_accept) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end else if (w_consume) begin
            r_main_valid <= 1'b0;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Both counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush && (r_main_valid || r_skid_valid) && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// tb_exe_mem_pipe_stage: directed self-checking bench for exe_mem_pipe_stage.
module tb_exe_mem_pipe_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_in;
    logic [2:0]  m_in;
    logic        zero_in;
    logic [31:0] pc_in;
    logic [31:0] alu_res_in;
    logic [31:0] rd2_in;
    logic [4:0]  dest_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  wb_out;
    logic [2:0]  m_out;
    logic        zero_out;
    logic [31:0] pc_out;
    logic [31:0] alu_res_out;
    logic [31:0] rd2_out;
    logic [4:0]  dest_out;
`ifdef PIPE_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif
    int n_cmp = 0;
    int n_err = 0;

    exe_mem_pipe_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .wb_in(wb_in), .m_in(m_in), .zero_in(zero_in), .pc_in(pc_in),
        .alu_res_in(alu_res_in), .rd2_in(rd2_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready), .wb_out(wb_out), .m_out(m_out),
        .zero_out(zero_out), .pc_out(pc_out), .alu_res_out(alu_res_out), .rd2_out(rd2_out),
`ifdef PIPE_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [1:0] wb, input logic [2:0] m);
        in_valid   = v;
        alu_res_in = alu;
        pc_in      = alu + 32'h100;
        rd2_in     = ~alu;
        dest_in    = alu[4:0];
        zero_in    = alu[0];
        wb_in      = wb;
        m_in       = m;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_alu", alu_res_out, 32'h0);
        tick(); tick();
        rst = 1'b0;

        // streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 2'b01, 3'b010);
            tick();
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_alu", alu_res_out, 32'(i));
            chk("stream_ready", 32'(in_ready), 32'h1);
        end
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        tick();
        chk("stream_drain", 32'(out_valid), 32'h0);

        // stall into the skid buffer, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 2'b10, 3'b101);
        tick();
        chk("stall_A_alu", alu_res_out, 32'hA);
        chk("stall_A_ready", 32'(in_ready), 32'h1);
        drive(1'b1, 32'hB, 2'b10, 3'b101);
        tick();
        chk("stall_B_alu", alu_res_out, 32'hA);
        chk("stall_B_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 32'hC, 2'b10, 3'b101);
        tick();
        chk("stall_C_held", alu_res_out, 32'hA);
        chk("stall_C_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        tick();
        chk("drain_B_alu", alu_res_out, 32'hB);
        chk("drain_B_pc", pc_out, 32'h10B);
        chk("drain_B_ready", 32'(in_ready), 32'h1);
        tick();
        chk("drain_C_alu", alu_res_out, 32'hC);
        chk("drain_C_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        tick();
        chk("drain_end_valid", 32'(out_valid), 32'h0);
        chk("drain_end_wb", 32'(wb_out), 32'h0);

        // flush with one entry held and a concurrent accept
        out_ready = 1'b0;
        drive(1'b1, 32'hD, 2'b11, 3'b111);
        tick();
        drive(1'b1, 32'hE, 2'b11, 3'b111);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush1_valid", 32'(out_valid), 32'h0);
        chk("flush1_ready", 32'(in_ready), 32'h1);
        chk("flush1_m", 32'(m_out), 32'h0);

        // flush with two entries held plus in_valid
        drive(1'b1, 32'h11, 2'b11, 3'b111);
        tick();
        drive(1'b1, 32'h12, 2'b11, 3'b111);
        tick();
        chk("flush2_pre_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 32'h13, 2'b11, 3'b111);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        chk("flush2_valid", 32'(out_valid), 32'h0);
        chk("flush2_ready", 32'(in_ready), 32'h1);
        chk("flush2_wb", 32'(wb_out), 32'h0);
        chk("flush2_m", 32'(m_out), 32'h0);
        out_ready = 1'b1;
        tick();
        chk("flush2_after", 32'(out_valid), 32'h0);

        // bubble gating
        drive(1'b1, 32'h55, 2'b11, 3'b111);
        tick();
        chk("bubble_wb_live", 32'(wb_out), 32'h3);
        chk("bubble_m_live", 32'(m_out), 32'h7);
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        tick();
        chk("bubble_valid", 32'(out_valid), 32'h0);
        chk("bubble_wb", 32'(wb_out), 32'h0);
        chk("bubble_m", 32'(m_out), 32'h0);
        chk("bubble_alu_kept", alu_res_out, 32'h55);

        // asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, 32'h21, 2'b01, 3'b001);
        tick();
        drive(1'b1, 32'h22, 2'b01, 3'b001);
        tick();
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h1);
        chk("arst_wb", 32'(wb_out), 32'h0);
        chk("arst_alu", alu_res_out, 32'h0);
        chk("arst_dest", 32'(dest_out), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_after", 32'(out_valid), 32'h0);

`ifdef PIPE_PERF_EN
        chk("perf_rst_stall", 32'(stall_cnt), 32'h0);
        drive(1'b1, 32'h31, 2'b01, 3'b001);
        tick();
        drive(1'b0, 32'h0, 2'b00, 3'b000);
        for (int i = 0; i < 5; i++) tick();
        chk("perf_stall5", 32'(stall_cnt), 32'h5);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_flush1", 32'(flush_cnt), 32'h1);
        chk("perf_stall_hold", 32'(stall_cnt), 32'h5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exe_mem_pipe_stage.md
Name: exe_mem_pipe_stage

Overview:
Parametrised EX→MEM pipeline boundary register for the MIPS pipeline. It carries WB/M control, zero flag, PC, ALU result, store data and destination register. Adds a valid/ready handshake with a 2-entry skid buffer, so stalls do not create a combinational ready path. Adds a synchronous flush for branch/exception squash, and bubble gating of control fields.

Parameters:
DATA_W, 32, width of pc, alu_res and rd2 fields
WB_W, 2, width of WB control field
M_W, 3, width of M control field
DEST_W, 5, destination register index width
CNT_W, 16, width of perf counters (only with PIPE_PERF_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous squash of all held entries
in_valid  in  1  EX stage presents an instruction
in_ready  out  1  stage can accept this cycle
wb_in  in  WB_W  WB control
m_in  in  M_W  M control
zero_in  in  1  ALU zero flag
pc_in  in  DATA_W  branch target / PC
alu_res_in  in  DATA_W  ALU result
rd2_in  in  DATA_W  store data
dest_in  in  DEST_W  destination register
out_valid  out  1  MEM stage has a valid instruction
out_ready  in  1  MEM stage consumes this cycle
wb_out, m_out, zero_out, pc_out, alu_res_out, rd2_out, dest_out  out  as inputs  registered fields
stall_cnt  out  CNT_W  (PIPE_PERF_EN only) cycles with out_valid & ~out_ready
flush_cnt  out  CNT_W  (PIPE_PERF_EN only) flushes that discarded ≥1 valid entry

Behaviour:
- Reset: clk domain, asynchronous, active-high rst. While rst=1: main_valid=0, skid_valid=0, all data registers 0, counters 0. Resulting outputs: out_valid=0, in_ready=1, all *_out=0.
- Storage: main register (drives outputs) and skid register. Both hold the full field bundle.
- accept = in_valid & in_ready. consume = out_valid & out_ready.
- in_ready = ~skid_valid, driven from a flop with no combinational path from out_ready.
- out_valid = main_valid.
- Latency: an instruction accepted in cycle N appears at the outputs in N+1 if main is empty or being consumed.
- Update rules, priority top-down:
  - flush=1: main_valid<=0, skid_valid<=0. Any concurrent accept is discarded. Data registers need not clear.
  - consume & skid_valid: main<=skid, skid_valid<=0. accept cannot occur because in_ready=0.
  - accept & (~main_valid | consume): main<=inputs, main_valid<=1.
  - accept & main_valid & ~consume: skid<=inputs, skid_valid<=1.
  - consume with no accept: main_valid<=0.
  - Otherwise hold all state.
- Bubble gating: wb_out and m_out read 0 whenever out_valid=0, so MEM/WB never write on a bubble. The other fields show the last main contents.
- Ordering: strictly FIFO. An entry is never duplicated or lost except by flush.
- Full throughput: with out_ready held at 1, one instruction per cycle and skid never used.
- Reset mid-operation: every held entry is dropped immediately, without waiting for a clock edge.

Optional Feature:
PIPE_PERF_EN
- Defined:
  - stall_cnt and flush_cnt ports exist. Both are CNT_W saturating counters; they stick at all-ones.
  - flush_cnt increments when flush=1 and (main_valid|skid_valid)=1.
  - Counters clear only on rst.
- Undefined: neither port nor counter logic exists. Datapath behaviour is identical.

Test Plan:
- Reset: rst pulse mid-stream with 2 entries held → asynchronously out_valid=0, in_ready=1, wb_out=0, m_out=0, all data 0.
- Streaming: out_ready=1, 8 back-to-back inputs alu_res=1..8 → outputs 1..8 in consecutive cycles, each 1 cycle after accept, in_ready stays 1.
- Stall/skid: out_ready=0 while sending A (alu_res=0xA) then B (0xB) → out_valid=1 showing A, in_ready=0 after B. Then out_ready=1 → A, then B, in_ready back to 1; no loss, no duplicate.
- Flush: two entries held plus in_valid=1 with flush=1 → next cycle out_valid=0, in_ready=1, wb_out=m_out=0. The concurrent input never appears.
- Bubble gating: wb_in=2'b11, m_in=3'b111 accepted, consumed, no new input → following cycle out_valid=0, wb_out=0, m_out=0.
- PIPE_PERF_EN: out_ready=0 for 5 cycles with a valid entry, then one flush with entries held → stall_cnt=5, flush_cnt=1. With CNT_W=2 and 6 stall cycles → stall_cnt=3 (saturated).
